// File: rtl/in_service_control_if.sv
// Signal bundle between the 8259A priority resolver/command side and the in-service control block.
// master drives requests, INTA and commands; slave returns ISR state, rotation and acknowledge results.
interface in_service_control_if;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge_n;
    logic       auto_eoi_config;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       set_priority_valid;
    logic [2:0] set_priority_level;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [7:0] clear_interrupt_request;
    logic [2:0] interrupt_vector_level;
    logic       end_of_acknowledge_sequence;

    modport master (
        output interrupt, interrupt_acknowledge_n, auto_eoi_config,
               eoi_valid, eoi_specific, eoi_rotate, eoi_level,
               set_priority_valid, set_priority_level,
        input  in_service_register, highest_level_in_service, priority_rotate,
               clear_interrupt_request, interrupt_vector_level, end_of_acknowledge_sequence
    );

    modport slave (
        input  interrupt, interrupt_acknowledge_n, auto_eoi_config,
               eoi_valid, eoi_specific, eoi_rotate, eoi_level,
               set_priority_valid, set_priority_level,
        output in_service_register, highest_level_in_service, priority_rotate,
               clear_interrupt_request, interrupt_vector_level, end_of_acknowledge_sequence
    );
endinterface

// File: rtl/in_service_control.sv
// 8259A in-service control: two-pulse INTA acknowledge sequencing, ISR ownership,
// EOI/AEOI handling and priority rotation fed back to the priority resolver.
module in_service_control (
    input  logic                 clock,
    input  logic                 reset,
    in_service_control_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q, inta_prev_d;
    logic [7:0] ack_onehot_q, ack_onehot_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clear_q, clear_d;
    logic [2:0] rotate_q, rotate_d;
    logic [2:0] level_q, level_d;
    logic       eoa_q, eoa_d;

    logic       fall, rise;
    logic [7:0] highest;
    logic [7:0] ack_set, eoi_clear, aeoi_clear;
    logic [2:0] cleared_level;

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign fall = inta_prev_q & ~bus.interrupt_acknowledge_n;
    assign rise = ~inta_prev_q & bus.interrupt_acknowledge_n;

    // Scan starts just above the lowest-priority level and wraps; the lowest level is checked last.
    always_comb begin
        logic [2:0] idx;
        highest = '0;
        idx     = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = rotate_q + 3'(i);
            if (highest == 8'h00 && isr_q[idx]) highest[idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        inta_prev_d   = bus.interrupt_acknowledge_n;
        ack_onehot_d  = ack_onehot_q;
        clear_d       = '0;
        level_d       = level_q;
        eoa_d         = 1'b0;
        rotate_d      = rotate_q;
        ack_set       = '0;
        aeoi_clear    = '0;
        eoi_clear     = '0;
        cleared_level = '0;

        unique case (state_q)
            IDLE: if (fall) begin
                state_d      = ACK1;
                ack_onehot_d = bus.interrupt;
                ack_set      = bus.interrupt;
                clear_d      = bus.interrupt;
                level_d      = (bus.interrupt == 8'h00) ? 3'd7 : encode(bus.interrupt);
            end
            ACK1: if (rise) state_d = GAP;
            GAP:  if (fall) state_d = ACK2;
            ACK2: if (rise) begin
                state_d = IDLE;
                eoa_d   = 1'b1;
                if (bus.auto_eoi_config) aeoi_clear = ack_onehot_q;
            end
            default: state_d = IDLE;
        endcase

        // EOI acts on the registered ISR, so an ack set in this same cycle survives it.
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                cleared_level = bus.eoi_level;
                eoi_clear     = isr_q & (8'h01 << bus.eoi_level);
            end else begin
                cleared_level = encode(highest);
                eoi_clear     = highest;
            end
            if (bus.eoi_rotate && eoi_clear != 8'h00) rotate_d = cleared_level;
        end

        if (bus.set_priority_valid) rotate_d = bus.set_priority_level;

        isr_d = (isr_q & ~eoi_clear & ~aeoi_clear) | ack_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            inta_prev_q  <= 1'b1;
            ack_onehot_q <= '0;
            isr_q        <= '0;
            clear_q      <= '0;
            rotate_q     <= 3'b111;
            level_q      <= '0;
            eoa_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            inta_prev_q  <= inta_prev_d;
            ack_onehot_q <= ack_onehot_d;
            isr_q        <= isr_d;
            clear_q      <= clear_d;
            rotate_q     <= rotate_d;
            level_q      <= level_d;
            eoa_q        <= eoa_d;
        end
    end

    assign bus.in_service_register         = isr_q;
    assign bus.highest_level_in_service    = highest;
    assign bus.priority_rotate             = rotate_q;
    assign bus.clear_interrupt_request     = clear_q;
    assign bus.interrupt_vector_level      = level_q;
    assign bus.end_of_acknowledge_sequence = eoa_q;
endmodule

// File: tb/tb_in_service_control.sv
// Cycle-by-cycle vector bench for in_service_control: each record gives the inputs for one
// clock edge and the outputs expected just after it, queued and popped as the DUT responds.
module tb_in_service_control;
    logic clock;
    logic reset;

    in_service_control_if bus ();

    in_service_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] irq;
        logic       inta;
        logic       aeoi;
        logic       ev;
        logic       es;
        logic       er;
        logic [2:0] el;
        logic       sv;
        logic [2:0] sl;
        logic [7:0] isr;
        logic [7:0] hi;
        logic [2:0] rot;
        logic [7:0] clr;
        logic [2:0] lvl;
        logic       eoa;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    function automatic vec_t mk(input string name, input logic rst, input logic [7:0] irq,
                                input logic inta, input logic aeoi, input logic ev, input logic es,
                                input logic er, input logic [2:0] el, input logic sv,
                                input logic [2:0] sl, input logic [7:0] isr, input logic [7:0] hi,
                                input logic [2:0] rot, input logic [7:0] clr, input logic [2:0] lvl,
                                input logic eoa);
        vec_t v;
        v.name = name; v.rst = rst; v.irq = irq; v.inta = inta; v.aeoi = aeoi;
        v.ev = ev; v.es = es; v.er = er; v.el = el; v.sv = sv; v.sl = sl;
        v.isr = isr; v.hi = hi; v.rot = rot; v.clr = clr; v.lvl = lvl; v.eoa = eoa;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        reset                       = v.rst;
        bus.interrupt               = v.irq;
        bus.interrupt_acknowledge_n = v.inta;
        bus.auto_eoi_config         = v.aeoi;
        bus.eoi_valid               = v.ev;
        bus.eoi_specific            = v.es;
        bus.eoi_rotate              = v.er;
        bus.eoi_level               = v.el;
        bus.set_priority_valid      = v.sv;
        bus.set_priority_level      = v.sl;
        exp_q.push_back(v);
    endtask

    task automatic check_output();
        vec_t e;
        e = exp_q.pop_front();
        vectors_applied++;
        if (bus.in_service_register !== e.isr || bus.highest_level_in_service !== e.hi ||
            bus.priority_rotate !== e.rot || bus.clear_interrupt_request !== e.clr ||
            bus.interrupt_vector_level !== e.lvl || bus.end_of_acknowledge_sequence !== e.eoa) begin
            miscompares++;
            $display("[TB] FAIL %s: got isr=%h hi=%h rot=%0d clr=%h lvl=%0d eoa=%b, want isr=%h hi=%h rot=%0d clr=%h lvl=%0d eoa=%b",
                     e.name, bus.in_service_register, bus.highest_level_in_service,
                     bus.priority_rotate, bus.clear_interrupt_request,
                     bus.interrupt_vector_level, bus.end_of_acknowledge_sequence,
                     e.isr, e.hi, e.rot, e.clr, e.lvl, e.eoa);
        end
    endtask

    task automatic step(input vec_t v);
        apply_stimulus(v);
        @(posedge clock);
        #1;
        check_output();
    endtask

    initial begin
        //            name            rst irq    inta aeoi ev es er el    sv sl     isr    hi     rot   clr    lvl   eoa
        vecs.push_back(mk("reset0",     1, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("reset1",     1, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("idle",       0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("ack2_fall1", 0, 8'h04, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h04, 8'h04, 3'd7, 8'h04, 3'd2, 0));
        vecs.push_back(mk("ack2_rise1", 0, 8'h04, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h04, 8'h04, 3'd7, 8'h00, 3'd2, 0));
        vecs.push_back(mk("ack2_fall2", 0, 8'h01, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h04, 8'h04, 3'd7, 8'h00, 3'd2, 0));
        vecs.push_back(mk("ack2_rise2", 0, 8'h01, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h04, 8'h04, 3'd7, 8'h00, 3'd2, 1));
        vecs.push_back(mk("ack2_after", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h04, 8'h04, 3'd7, 8'h00, 3'd2, 0));
        vecs.push_back(mk("nest_fall1", 0, 8'h01, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h05, 8'h01, 3'd7, 8'h01, 3'd0, 0));
        vecs.push_back(mk("nest_rise1", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h05, 8'h01, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("nest_fall2", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h05, 8'h01, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("nest_rise2", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h05, 8'h01, 3'd7, 8'h00, 3'd0, 1));
        vecs.push_back(mk("ns_eoi",     0, 8'h00, 1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 8'h04, 8'h04, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("spec_eoi2",  0, 8'h00, 1, 0, 1, 1, 0, 3'd2, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("spec_clr5r", 0, 8'h00, 1, 0, 1, 1, 1, 3'd5, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("ns_empty_r", 0, 8'h00, 1, 0, 1, 0, 1, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("ack3_fall1", 0, 8'h08, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h08, 8'h08, 3'd7, 8'h08, 3'd3, 0));
        vecs.push_back(mk("ack3_rise1", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h08, 8'h08, 3'd7, 8'h00, 3'd3, 0));
        vecs.push_back(mk("ack3_fall2", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h08, 8'h08, 3'd7, 8'h00, 3'd3, 0));
        vecs.push_back(mk("ack3_rise2", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h08, 8'h08, 3'd7, 8'h00, 3'd3, 1));
        vecs.push_back(mk("rot_eoi",    0, 8'h00, 1, 0, 1, 0, 1, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd3, 8'h00, 3'd3, 0));
        vecs.push_back(mk("ack0_fall1", 0, 8'h01, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h01, 8'h01, 3'd3, 8'h01, 3'd0, 0));
        vecs.push_back(mk("ack0_rise1", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h01, 8'h01, 3'd3, 8'h00, 3'd0, 0));
        vecs.push_back(mk("ack0_fall2", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h01, 8'h01, 3'd3, 8'h00, 3'd0, 0));
        vecs.push_back(mk("ack0_rise2", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h01, 8'h01, 3'd3, 8'h00, 3'd0, 1));
        vecs.push_back(mk("ack4_fall1", 0, 8'h10, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h11, 8'h10, 3'd3, 8'h10, 3'd4, 0));
        vecs.push_back(mk("ack4_rise1", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h11, 8'h10, 3'd3, 8'h00, 3'd4, 0));
        vecs.push_back(mk("ack4_fall2", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h11, 8'h10, 3'd3, 8'h00, 3'd4, 0));
        vecs.push_back(mk("ack4_rise2", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h11, 8'h10, 3'd3, 8'h00, 3'd4, 1));
        vecs.push_back(mk("setpri_win", 0, 8'h00, 1, 0, 1, 0, 1, 3'd0, 1, 3'd7, 8'h01, 8'h01, 3'd7, 8'h00, 3'd4, 0));
        vecs.push_back(mk("spec_eoi0",  0, 8'h00, 1, 0, 1, 1, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd4, 0));
        vecs.push_back(mk("aeoi_fall1", 0, 8'h20, 0, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h20, 8'h20, 3'd7, 8'h20, 3'd5, 0));
        vecs.push_back(mk("aeoi_rise1", 0, 8'h00, 1, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h20, 8'h20, 3'd7, 8'h00, 3'd5, 0));
        vecs.push_back(mk("aeoi_fall2", 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h20, 8'h20, 3'd7, 8'h00, 3'd5, 0));
        vecs.push_back(mk("aeoi_rise2", 0, 8'h00, 1, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd5, 1));
        vecs.push_back(mk("aeoi_after", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd5, 0));
        vecs.push_back(mk("spur_fall1", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));
        vecs.push_back(mk("spur_rise1", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));
        vecs.push_back(mk("spur_fall2", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));
        vecs.push_back(mk("spur_rise2", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 1));
        vecs.push_back(mk("rst_fall1",  0, 8'h02, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h02, 8'h02, 3'd7, 8'h02, 3'd1, 0));
        vecs.push_back(mk("rst_rise1",  0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h02, 8'h02, 3'd7, 8'h00, 3'd1, 0));
        vecs.push_back(mk("rst_in_gap", 1, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd0, 0));
        vecs.push_back(mk("post_fall",  0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));
        vecs.push_back(mk("post_rise",  0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));
        vecs.push_back(mk("post_fall2", 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));
        vecs.push_back(mk("post_rise2", 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 1));
        vecs.push_back(mk("setpri2",    0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 1, 3'd2, 8'h00, 8'h00, 3'd2, 8'h00, 3'd7, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // An EOI landing on the same edge as a first fall only sees the old ISR, so the new bit survives.
        step(mk("same_cyc_eoi", 0, 8'h80, 0, 0, 1, 1, 1, 3'd7, 0, 3'd0, 8'h80, 8'h80, 3'd2, 8'h80, 3'd7, 0));
        step(mk("same_rise1",   0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h80, 8'h80, 3'd2, 8'h00, 3'd7, 0));
        step(mk("same_fall2",   0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h80, 8'h80, 3'd2, 8'h00, 3'd7, 0));
        step(mk("same_rise2",   0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 8'h80, 8'h80, 3'd2, 8'h00, 3'd7, 1));
        step(mk("rot_eoi7",     0, 8'h00, 1, 0, 1, 0, 1, 3'd0, 0, 3'd0, 8'h00, 8'h00, 3'd7, 8'h00, 3'd7, 0));

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule

// File: doc/in_service_control.md
# in_service_control

Downstream stage of `priority_resolver` in the 8259A PIC. It consumes the one-hot `interrupt` winner, runs the two-pulse INTA acknowledge sequence, owns the in-service register (ISR), and handles EOI, automatic EOI, and priority rotation. It feeds `ISR`, `highest_level_in_service` and `priority_rotate` back to `priority_resolver`, and sends IRR clear strobes to the request register.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `interrupt`  in  8  one-hot winning request from `priority_resolver`; all-zero means no request.
- `interrupt_acknowledge_n`  in  1  INTA#, already synchronised to `clock`.
- `auto_eoi_config`  in  1  1 enables automatic EOI at the end of the sequence.
- `eoi_valid`  in  1  one-cycle EOI command strobe.
- `eoi_specific`  in  1  with `eoi_valid`: 1 = specific EOI, 0 = non-specific EOI.
- `eoi_rotate`  in  1  with `eoi_valid`: rotate priority on the cleared level.
- `eoi_level`  in  3  level for a specific EOI.
- `set_priority_valid`  in  1  one-cycle strobe: `priority_rotate <= set_priority_level`.
- `set_priority_level`  in  3  new lowest-priority level.
- `in_service_register`  out  8  ISR.
- `highest_level_in_service`  out  8  one-hot highest-priority set ISR bit under the current rotation; 0 when ISR = 0.
- `priority_rotate`  out  3  lowest-priority level; highest priority is `priority_rotate+1` mod 8.
- `clear_interrupt_request`  out  8  one-cycle IRR clear pulse.
- `interrupt_vector_level`  out  3  acknowledged level, latched at the first INTA.
- `end_of_acknowledge_sequence`  out  1  one-cycle pulse when the sequence completes.

## Operation
- Edge detection:
  - `inta_prev` is registered, with reset value 1.
  - fall = `inta_prev & ~interrupt_acknowledge_n`; rise = `~inta_prev & interrupt_acknowledge_n`.
- State machine, states IDLE, ACK1, GAP, ACK2:
  - IDLE --fall--> ACK1. On this transition `interrupt` is sampled into `ack_onehot`.
  - ACK1 --rise--> GAP.
  - GAP --fall--> ACK2.
  - ACK2 --rise--> IDLE. `end_of_acknowledge_sequence` pulses on this transition.
  - Any other input leaves the state unchanged.
- Valid first fall (`ack_onehot` != 0):
  - set the ISR bit;
  - `clear_interrupt_request <= ack_onehot` for one cycle;
  - `interrupt_vector_level <=` encoded level.
- Spurious first fall (`interrupt` = 0):
  - ISR unchanged, no clear pulse;
  - `interrupt_vector_level <= 7`;
  - the sequence still completes.
- AEOI: when `auto_eoi_config` = 1, the ACK2→IDLE transition clears the `ack_onehot` bit from ISR. There is no rotation.
- EOI, on `eoi_valid`:
  - Non-specific: clear `highest_level_in_service` from ISR.
  - Specific: clear bit `eoi_level`.
  - If `eoi_rotate` = 1 and the cleared bit was set: `priority_rotate <=` cleared level.
  - Non-specific EOI with ISR = 0: no effect.
  - Specific EOI on a clear bit: no ISR change and no rotation.
- Set priority: `set_priority_valid` loads `priority_rotate`. If it coincides with a rotating EOI, `set_priority_valid` wins.
- ISR update rule: `ISR_next = (ISR & ~eoi_clear & ~aeoi_clear) | ack_set`.
  - `eoi_clear` is computed from the current ISR, so a same-cycle ack set is never cleared by that EOI.
- `highest_level_in_service` is combinational from the registered ISR and `priority_rotate`. Scan order: `priority_rotate+1`, `+2`, … (mod 8).
- Reset at any point, including mid-sequence:
  - state IDLE; ISR 0; `priority_rotate` 3'b111; all pulses 0;
  - `interrupt_vector_level` 0; `inta_prev` 1.
  - A later INTA rise does not generate `end_of_acknowledge_sequence`.

## Timing
- Reset values:
  - `in_service_register` 8'h00; `highest_level_in_service` 8'h00; `priority_rotate` 3'b111;
  - `clear_interrupt_request` 8'h00; `interrupt_vector_level` 3'd0; `end_of_acknowledge_sequence` 0.
- First INTA low sampled at edge N:
  - ISR bit, `clear_interrupt_request` and `interrupt_vector_level` are visible after edge N;
  - the clear pulse drops after edge N+1.
- Second INTA rise sampled at edge M:
  - `end_of_acknowledge_sequence` is high for the cycle after M;
  - the AEOI clear is visible after M.
- EOI and set-priority strobes at edge K take effect after K, one-cycle latency.
- `highest_level_in_service` follows ISR and `priority_rotate` in the same cycle, with no added latency.
- `interrupt` is ignored outside the IDLE→ACK1 transition. The winner is frozen for the whole sequence.
- Minimum INTA low and high width: one `clock` cycle each.

## Test plan
- Reset check: hold `reset` 2 cycles → ISR 00, `priority_rotate` 111, `highest_level_in_service` 00, `clear_interrupt_request` 00, `interrupt_vector_level` 0.
- Basic ack: `interrupt` = 00000100, two INTA pulses, AEOI = 0 → after the first fall ISR = 00000100, clear = 00000100 for exactly one cycle, level = 2; a one-cycle `end_of_acknowledge_sequence` after the second rise; ISR stays 00000100.
- Nesting and non-specific EOI: ISR = 00000100, then ack `interrupt` = 00000001 → ISR = 00000101, highest = 00000001; non-specific EOI → ISR = 00000100, highest = 00000100.
- Rotating EOI: ISR = 00001000, non-specific EOI with rotate → ISR = 0, `priority_rotate` = 3. Then set ISR = 00010001 via acks → highest = 00010000 (IR4 now outranks IR0).
- AEOI: `auto_eoi_config` = 1, ack `interrupt` = 00100000 → ISR = 00100000 between pulses, 00000000 after the second rise, `priority_rotate` unchanged.
- Spurious and reset mid-sequence: `interrupt` = 0 at the first fall → ISR unchanged, no clear pulse, level = 7. Separately, `reset` asserted in GAP → IDLE, ISR 0, and no `end_of_acknowledge_sequence` on later INTA edges until a new first fall.
